serial_negedge_rx: RTL and testbench
====================================

// Module: serial_negedge_rx
// PURPOSE
//  Receive end of the mixed-edge serial link. The upstream launcher drives SDI/SFRM
//  on posedge CLK; this block samples them on negedge CLK (half-cycle margin).
//  It deserializes LSB-first words and retimes each completed word onto posedge CLK.
//  Words are presented through a small FIFO with a valid/ready handshake to core logic.
// PARAMETERS
//  WIDTH  8  data bits per word (>=2)
//  DEPTH  2  output FIFO entries (power of 2, >=2)
// PORTS
//  CLK     in   1      single clock; front-end uses negedge, back-end uses posedge
//  RST     in   1      asynchronous, active-high reset, acts on all flops of both edges
//  SDI     in   1      serial data, launched on posedge CLK
//  SFRM    in   1      frame strobe, high with bit 0 of each word
//  DOUT    out  WIDTH  FIFO head word
//  DVALID  out  1      FIFO not empty
//  DREADY  in   1      consumer accepts DOUT on posedge when DVALID=1
//  OVF     out  1      sticky: a completed word was dropped because the FIFO was full
//  FERR    out  1      sticky: SFRM seen mid-word, partial word discarded
//  PERR    out  1      sticky parity error (PARITY_CHECK_EN builds only)
// BEHAVIOUR
//  Reset: DOUT=0, DVALID=0, OVF=0, FERR=0, PERR=0, FSM=IDLE, bit count=0, FIFO empty.
//   Stickies clear only on RST.
//  Front-end FSM (negedge CLK), samples SDI and SFRM:
//   IDLE:  SFRM=1 -> shreg[0]=SDI, cnt=1, go SHIFT. SFRM=0 -> stay; SDI ignored.
//   SHIFT: SFRM=0 -> shreg[cnt]=SDI, cnt++. When cnt reaches WIDTH the word is complete.
//          SFRM=1 -> set FERR, discard partial word, restart with shreg[0]=SDI, cnt=1.
//   On completion: load word into hand-off reg, toggle pnd flag, go IDLE.
//   In the same negedge, SFRM=1 starts the next word (back-to-back frames, no gap cycle).
//  Hand-off: posedge logic detects a pnd toggle and pushes the hand-off reg into the FIFO.
//   Latency: last data bit sampled at negedge N -> DVALID=1 after the following posedge
//   (half cycle).
//   Hand-off reg is stable for >= WIDTH negedges, so it never overruns.
//  FIFO (posedge CLK): pop when DVALID & DREADY. DOUT holds the head; it is don't-care
//   when empty but holds its last value.
//   Full + push, no pop: word dropped, OVF=1, FIFO contents unchanged.
//   Full + push + pop on the same edge: both succeed, no OVF.
//   Empty + push + DREADY=1: word visible only after that edge (no fall-through).
//   Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSB differs, rest equal.
//  RST asserted mid-word: partial word and FIFO contents are lost; FSM returns to IDLE
//   immediately.
//   After deassertion, the first word is the first one framed by SFRM=1.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//   - One extra bit follows the data bits: cnt==WIDTH enters state PARITY.
//   - Odd parity over data+parity is required.
//   - Mismatch: word discarded (no push), PERR=1. Match: normal completion.
//   - SFRM=1 in PARITY behaves as in SHIFT (FERR, restart).
//   - Frame length is WIDTH+1 bits.
//  PARITY_CHECK_EN undefined:
//   - No PARITY state and no PERR port. Frame length is WIDTH bits.
// TESTING
//  1 reset: RST=1 for 20 time units mid-frame -> all outputs 0. First SFRM-framed word
//    after release received intact.
//  2 single word: WIDTH=8, send 0xA5 LSB-first, DREADY=0 -> DVALID=1 half cycle after
//    the 8th negedge, DOUT=8'hA5.
//  3 back-to-back overflow: DEPTH=2, send 0x01, 0x02, 0x03 with no gap, DREADY=0 ->
//    FIFO holds 0x01, 0x02; OVF=1.
//    Then DREADY=1 -> pops 0x01 then 0x02, DVALID drops.
//  4 full with same-edge pop: FIFO full and DREADY=1 on the push edge -> no OVF; order
//    0x01, 0x02, 0x03 preserved.
//  5 framing error: SFRM=1 again after 3 bits, then 8 bits of 0x3C -> FERR=1; only 0x3C
//    delivered.
//  6 PARITY_CHECK_EN: 0x07 with parity 0 -> accepted.
//    0x07 with parity 1 -> PERR=1, no DVALID.

Source files
------------

// File: rtl/serial_negedge_rx_if.sv
// Bundle for the mixed-edge serial receiver: launcher/consumer side is master,
// the receiver is slave. PERR exists only when PARITY_CHECK_EN is defined.
interface serial_negedge_rx_if #(
   parameter int WIDTH = 8
);
   logic             sdi;
   logic             sfrm;
   logic             dready;
   logic [WIDTH-1:0] dout;
   logic             dvalid;
   logic             ovf;
   logic             ferr;
`ifdef PARITY_CHECK_EN
   logic             perr;

   modport master (output sdi, sfrm, dready, input dout, dvalid, ovf, ferr, perr);
   modport slave  (input sdi, sfrm, dready, output dout, dvalid, ovf, ferr, perr);
`else
   modport master (output sdi, sfrm, dready, input dout, dvalid, ovf, ferr);
   modport slave  (input sdi, sfrm, dready, output dout, dvalid, ovf, ferr);
`endif
endinterface

// File: rtl/serial_negedge_rx.sv
// Mixed-edge serial receiver: negedge deserializer, posedge hand-off into a small FIFO.
// Optional odd-parity check is built when PARITY_CHECK_EN is defined.
module serial_negedge_rx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   serial_negedge_rx_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           state_q;
   logic [IW-1:0]    cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] hoff_q;
   logic             pnd_q;
   logic             ferr_q;
`ifdef PARITY_CHECK_EN
   logic             perr_q;
`endif
   logic [WIDTH-1:0] word_ins;
   logic [WIDTH-1:0] first_word;

   always_comb begin
      word_ins        = shreg_q;
      word_ins[cnt_q] = bus.sdi;
      first_word      = {{(WIDTH-1){1'b0}}, bus.sdi};
   end

   // Front end: a completed word is published by toggling pnd_q next to a stable hoff_q.
   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         hoff_q  <= '0;
         pnd_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.sfrm) begin
                  shreg_q <= first_word;
                  cnt_q   <= IW'(1);
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.sfrm) begin
                  ferr_q  <= 1'b1;
                  shreg_q <= first_word;
                  cnt_q   <= IW'(1);
               end else if (cnt_q == LAST_BIT) begin
                  cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
                  shreg_q <= word_ins;
                  state_q <= S_PARITY;
`else
                  hoff_q  <= word_ins;
                  pnd_q   <= ~pnd_q;
                  state_q <= S_IDLE;
`endif
               end else begin
                  shreg_q <= word_ins;
                  cnt_q   <= cnt_q + IW'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
               if (bus.sfrm) begin
                  ferr_q  <= 1'b1;
                  shreg_q <= first_word;
                  cnt_q   <= IW'(1);
                  state_q <= S_SHIFT;
               end else begin
                  if (^{shreg_q, bus.sdi}) begin
                     hoff_q <= shreg_q;
                     pnd_q  <= ~pnd_q;
                  end else begin
                     perr_q <= 1'b1;
                  end
                  state_q <= S_IDLE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic             pnd_seen_q;
   logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             push, pop, full, empty, push_ok;

   // DOUT is registered as the head after this edge; a lone fresh word comes from hoff_q.
   always_comb begin
      push    = pnd_q ^ pnd_seen_q;
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop     = !empty && bus.dready;
      push_ok = push && (!full || pop);
      ovf_d   = ovf_q | (push && !push_ok);
      wr_d    = wr_q + PW'(push_ok);
      rd_d    = rd_q + PW'(pop);
      dout_d  = dout_q;
      if (rd_d != wr_d) begin
         if (rd_d == wr_q) dout_d = hoff_q;
         else              dout_d = mem_q[rd_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pnd_seen_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         dout_q     <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         pnd_seen_q <= pnd_q;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         dout_q     <= dout_d;
         ovf_q      <= ovf_d;
         if (push_ok) mem_q[wr_q[AW-1:0]] <= hoff_q;
      end
   end

   assign bus.dout   = dout_q;
   assign bus.dvalid = !empty;
   assign bus.ovf    = ovf_q;
   assign bus.ferr   = ferr_q;
`ifdef PARITY_CHECK_EN
   assign bus.perr   = perr_q;
`endif

endmodule

// File: tb/tb_serial_negedge_rx.sv
// Randomized bench for serial_negedge_rx: frames are scheduled per cycle and the
// expected output stream comes from a queue-based FIFO model fed by frame outcomes.
module tb_serial_negedge_rx;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
`ifdef PARITY_CHECK_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif

   typedef struct {
      logic             sdi;
      logic             sfrm;
      logic             dready;
      logic             done;
      logic [WIDTH-1:0] word;
      logic             ferr_ev;
      logic             perr_ev;
      logic             rst_after;
   } cyc_t;

   cyc_t             stim [$];
   logic [WIDTH-1:0] model_q [$];
   bit               prev_trunc;
   bit               m_ovf, m_ferr, m_perr;
   int               n_checks, n_fail;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   cyc_t             c;

   always #5 clk = ~clk;

   serial_negedge_rx_if #(.WIDTH(WIDTH)) bus ();

   serial_negedge_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic pick(input int mode);
      if (mode == 2) return 1'($urandom_range(0, 1));
      return (mode == 1);
   endfunction

   // nbits < FLEN sends a truncated frame; the following frame's SFRM then flags FERR.
   task automatic add_frame(input logic [WIDTH-1:0] w, input int nbits, input bit bad_par,
                            input int rdy, input int rdy_last);
      logic [FLEN-1:0] bits;
      cyc_t            e;
      bits = '0;
      bits[WIDTH-1:0] = w;
`ifdef PARITY_CHECK_EN
      bits[WIDTH] = bad_par ? (^w) : ~(^w);
`endif
      for (int i = 0; i < nbits; i++) begin
         e.sdi       = bits[i];
         e.sfrm      = (i == 0);
         e.dready    = (i == nbits - 1) ? pick(rdy_last) : pick(rdy);
         e.done      = 1'b0;
         e.word      = w;
         e.ferr_ev   = (i == 0) && prev_trunc;
         e.perr_ev   = 1'b0;
         e.rst_after = 1'b0;
         if (i == nbits - 1 && nbits == FLEN) begin
            if (bad_par && FLEN > WIDTH) e.perr_ev = 1'b1;
            else                         e.done    = 1'b1;
         end
         stim.push_back(e);
      end
      prev_trunc = (nbits < FLEN);
   endtask

   task automatic add_gap(input int n, input int rdy);
      cyc_t e;
      for (int i = 0; i < n; i++) begin
         e.sdi       = 1'($urandom_range(0, 1));
         e.sfrm      = 1'b0;
         e.dready    = pick(rdy);
         e.done      = 1'b0;
         e.word      = '0;
         e.ferr_ev   = 1'b0;
         e.perr_ev   = 1'b0;
         e.rst_after = 1'b0;
         stim.push_back(e);
      end
   endtask

   task automatic add_random(input int nframes);
      bit trunc;
      for (int f = 0; f < nframes; f++) begin
         trunc = (f != nframes - 1) && ($urandom_range(0, 9) < 2);
         add_frame(WIDTH'($urandom), trunc ? $urandom_range(1, FLEN - 1) : FLEN,
                   ($urandom_range(0, 99) < 15), 2, 2);
         if (!prev_trunc) add_gap($urandom_range(0, 3), 2);
      end
   endtask

   task automatic check_outputs(input string sfx);
      check_eq({"dvalid", sfx}, 32'(bus.dvalid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check_eq({"dout", sfx}, 32'(bus.dout), 32'(model_q[0]));
      check_eq({"ovf", sfx},  32'(bus.ovf),  32'(m_ovf));
      check_eq({"ferr", sfx}, 32'(bus.ferr), 32'(m_ferr));
`ifdef PARITY_CHECK_EN
      check_eq({"perr", sfx}, 32'(bus.perr), 32'(m_perr));
`endif
   endtask

   initial begin
      bus.sdi    = 1'b0;
      bus.sfrm   = 1'b0;
      bus.dready = 1'b0;
      prev_trunc = 1'b0;

      add_gap(3, 0);
      add_frame(8'hA5, FLEN, 1'b0, 0, 0);           // single word, consumer stalled
      add_gap(2, 0);
      add_gap(3, 1);
      add_frame(8'h01, FLEN, 1'b0, 0, 0);           // full FIFO popped on the push edge
      add_frame(8'h02, FLEN, 1'b0, 0, 0);
      add_frame(8'h03, FLEN, 1'b0, 0, 1);
      add_gap(4, 1);
      add_frame(8'h55, 3, 1'b0, 0, 0);              // framing error then 0x3C
      add_frame(8'h3C, FLEN, 1'b0, 0, 0);
      add_gap(3, 1);
      add_frame(8'h07, FLEN, 1'b0, 0, 0);           // parity good / bad
      add_frame(8'h07, FLEN, 1'b1, 0, 0);
      add_gap(3, 1);
      add_frame(8'h01, FLEN, 1'b0, 0, 0);           // back-to-back overflow
      add_frame(8'h02, FLEN, 1'b0, 0, 0);
      add_frame(8'h03, FLEN, 1'b0, 0, 0);
      add_gap(4, 1);
      add_random(40);
      add_frame(WIDTH'($urandom), $urandom_range(2, FLEN - 1), 1'b0, 2, 2);
      stim[stim.size() - 1].rst_after = 1'b1;
      prev_trunc = 1'b0;
      add_random(12);
      add_gap(6, 1);

      #23;
      check_outputs("_por");
      rst = 1'b0;

      while (stim.size() > 0) begin
         c = stim.pop_front();
         @(posedge clk);
         #1;
         bus.sdi    = c.sdi;
         bus.sfrm   = c.sfrm;
         bus.dready = c.dready;
         #6;
         if (c.ferr_ev) m_ferr = 1'b1;
         if (c.perr_ev) m_perr = 1'b1;
         check_outputs("");
         if (c.dready && model_q.size() != 0) begin
            $display("pop word %02h", model_q[0]);
            void'(model_q.pop_front());
         end
         if (c.done) begin
            if (model_q.size() < DEPTH) model_q.push_back(c.word);
            else                        m_ovf = 1'b1;
         end
         if (c.rst_after) begin
            bus.sfrm = 1'b0;
            rst      = 1'b1;
            model_q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
            #1;
            check_outputs("_rst");
            #19;
            rst = 1'b0;
            $display("mid-frame reset released at %0t", $time);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
